serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 29 ++
 rtl/serial_addsub.sv | 109 ++++++++++
 tb/tb_serial_addsub.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
// serial_addsub_if : operand/result bundle for the bit-serial add/sub unit
// Rev 1.0
// ============================================================================
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] Data0;
   logic [WIDTH-1:0] Data1;
   logic             mode;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] final_sum;
   logic             final_carry_out;
   logic             overflow;

   modport master (
      output start, Data0, Data1, mode,
      input  busy, done, final_sum, final_carry_out, overflow
   );

   modport slave (
      input  start, Data0, Data1, mode,
      output busy, done, final_sum, final_carry_out, overflow
   );
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// serial_addsub : bit-serial two's-complement adder/subtractor, LSB first
// Rev 1.0
// ============================================================================
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   serial_addsub_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
   localparam logic [CW-1:0] c_one  = CW'(1);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_sum;
   logic [WIDTH-2:0] w_sum_next;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_final_sum;
   logic             r_final_carry;
   logic             r_overflow;
   logic             w_accept;
   logic             w_last;
   logic             w_s;
   logic             w_cout;

   assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_state == S_RUN) && (r_cnt == c_last);

   assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

   // New bits enter at the top of the partial-sum register and drift down.
   generate
      if (WIDTH > 2) begin : g_sum_wide
         assign w_sum_next = {w_s, r_sum[WIDTH-2:1]};
      end else begin : g_sum_narrow
         assign w_sum_next = w_s;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next_state = S_RUN;
         S_RUN:   if (w_last)    w_next_state = S_DONE;
         S_DONE:  w_next_state = bus.start ? S_RUN : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a           <= '0;
         r_b           <= '0;
         r_sum         <= '0;
         r_carry       <= 1'b0;
         r_cnt         <= '0;
         r_final_sum   <= '0;
         r_final_carry <= 1'b0;
         r_overflow    <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is A + ~B + 1: invert B and seed the carry.
         r_a     <= bus.Data0;
         r_b     <= bus.mode ? bus.Data1 : ~bus.Data1;
         r_carry <= ~bus.mode;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_sum   <= w_sum_next;
         r_carry <= w_cout;
         r_cnt   <= r_cnt + c_one;
         if (w_last) begin
            // r_carry still holds the carry into the MSB on this edge.
            r_final_sum   <= {w_s, r_sum};
            r_final_carry <= w_cout;
            r_overflow    <= r_carry ^ w_cout;
         end
      end
   end

   assign bus.busy            = (r_state == S_RUN);
   assign bus.done            = (r_state == S_DONE);
   assign bus.final_sum       = r_final_sum;
   assign bus.final_carry_out = r_final_carry;
   assign bus.overflow        = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// tb_serial_addsub : scoreboard bench with an arithmetic reference model
// Rev 1.0
// ============================================================================
module tb_serial_addsub;
   localparam int W  = 8;
   localparam int CW = 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         c;
      logic         v;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t mon_e;

   serial_addsub_if #(.WIDTH(W)) bus();
   serial_addsub #(.WIDTH(W), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer arithmetic, signed range check for overflow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      exp_t e;
      int ua, ub, sa, sb, raw, sr;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
      sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
      raw = m ? ua + ub : ua - ub;
      e.sum = W'(raw);
      e.c   = m ? (raw >= 2**W) : (ua >= ub);
      sr    = m ? sa + sb : sa - sb;
      e.v   = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
      e.cyc = 0;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive a start at the current negedge; done is due in the cycle after edge+W.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, output int t);
      exp_t e;
      e = model(a, b, m);
      e.cyc = cyc + 1 + W;
      t = e.cyc;
      q.push_back(e);
      bus.start = 1'b1;
      bus.Data0 = a;
      bus.Data1 = b;
      bus.mode  = m;
      @(negedge clk);
      bus.start = 1'b0;
      bus.Data0 = W'($urandom);
      bus.Data1 = W'($urandom);
      bus.mode  = 1'($urandom);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input int gap);
      int t;
      issue(a, b, m, t);
      wait_cyc(t);
      repeat (gap) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(bus.busy), 0);
      check({tag, "_done"},  32'(bus.done), 0);
      check({tag, "_sum"},   32'(bus.final_sum), 0);
      check({tag, "_carry"}, 32'(bus.final_carry_out), 0);
      check({tag, "_ovf"},   32'(bus.overflow), 0);
   endtask

   // Monitor: every done must match the head of the scoreboard, on its exact cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: done at cycle %0d, none pending", cyc);
            end else if (q[0].cyc != cyc) begin
               errors++;
               $display("FAIL done_timing: done at cycle %0d expected cycle %0d", cyc, q[0].cyc);
            end else begin
               mon_e = q.pop_front();
               check("final_sum", 32'(bus.final_sum), 32'(mon_e.sum));
               check("final_carry_out", 32'(bus.final_carry_out), 32'(mon_e.c));
               check("overflow", 32'(bus.overflow), 32'(mon_e.v));
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL done_missing: no done at cycle %0d expected cycle %0d", cyc, q[0].cyc);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int t, t2, nb;
      logic [W-1:0] a, b;
      logic m;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.Data0 = '0;
      bus.Data1 = '0;
      bus.mode  = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic add with busy-window measurement.
      issue(8'h35, 8'h1A, 1'b1, t);
      nb = 0;
      repeat (W + 3) begin
         if (bus.busy) nb++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(nb), 32'(W));

      run(8'h7F, 8'h01, 1'b1, 1);
      run(8'hFF, 8'h01, 1'b1, 1);
      run(8'h05, 8'h07, 1'b0, 1);
      run(8'h80, 8'h01, 1'b0, 1);

      // Start during RUN is ignored; start in the done cycle is accepted.
      issue(8'h10, 8'h20, 1'b1, t);
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.Data0 = 8'hAA;
      bus.Data1 = 8'h55;
      bus.mode  = 1'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
      wait_cyc(t);
      issue(8'h09, 8'h03, 1'b0, t2);
      check("done_single_pulse", 32'(bus.done), 0);
      check("busy_back_to_back", 32'(bus.busy), 1);
      while (cyc < t2) begin
         check("held_sum", 32'(bus.final_sum), 32'h30);
         @(negedge clk);
      end
      @(negedge clk);

      // Asynchronous reset mid-operation discards the result.
      issue(8'h5A, 8'h33, 1'b1, t);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (W + 2) @(negedge clk);
      run(8'h3C, 8'h44, 1'b0, 1);

      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         m = 1'($urandom);
         run(a, b, m, int'($urandom_range(0, 3)));
      end

      repeat (W + 3) @(negedge clk);
      check("queue_drained", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
